// File: rtl/cp0_timer_unit.sv
// MIPS system-control coprocessor: SR, Cause, EPC, PRId, BadVAddr with HWINT_W external interrupt lines.
// The Count/Compare timer (regs 9/11, TI on IP[7]) is built only when CP0_TIMER_UNIT_TIMER_EN is defined.
`timescale 1ns/1ps
module cp0_timer_unit #(
  parameter int          HWINT_W   = 6,
  parameter logic [31:0] PRID_VAL  = 32'h19260817,
  parameter int          TIMER_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A,
  input  logic [31:0]        Din,
  input  logic               WE,
  output logic [31:0]        Dout,
  input  logic               ExcReq,
  input  logic [4:0]         ExcCodeIn,
  input  logic [29:0]        PCIn,
  input  logic               BDIn,
  input  logic [31:0]        BadVAddrIn,
  input  logic [HWINT_W-1:0] HWInt,
  output logic               ExcNow,
  input  logic               EXLClr,
  output logic [31:0]        EPCOut
);

  logic [7:2]  im;
  logic [7:2]  ip;
  logic [7:2]  ip_next;
  logic        exl;
  logic        ie;
  logic        bd;
  logic        ti;
  logic [4:0]  exc_code;
  logic [29:0] epc;
  logic [31:0] badvaddr;
  logic        int_req;
  logic        mtc0_en;

  // Interrupts see the registered IP, so a line change is visible one cycle later.
  assign int_req = ~exl & ie & (|(ip & im));
  assign ExcNow  = ExcReq | int_req;
  assign mtc0_en = WE & ~ExcNow & ~EXLClr;
  assign EPCOut  = {epc, 2'b00};

  always_comb begin
    ip_next = '0;
    for (int i = 0; i < HWINT_W; i++) ip_next[2+i] = HWInt[i];
    ip_next[7] = ip_next[7] | ti;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      ip       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip <= ip_next;
      if (ExcNow) begin
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        bd       <= BDIn;
        epc      <= BDIn ? (PCIn - 30'd1) : PCIn;
        exl      <= 1'b1;
        if (!int_req && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) badvaddr <= BadVAddrIn;
      end else if (EXLClr) begin
        exl <= 1'b0;
      end else if (mtc0_en) begin
        case (A)
          5'd12: begin
            im  <= Din[15:10];
            exl <= Din[1];
            ie  <= Din[0];
          end
          5'd14:   epc <= Din[31:2];
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_UNIT_TIMER_EN
  localparam logic [31:0] DIV_LAST = 32'(TIMER_DIV - 1);

  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] presc;
  logic [31:0] count_inc;
  logic        tick;
  logic        wr_count;
  logic        wr_compare;

  assign tick       = (presc == DIV_LAST);
  assign count_inc  = count + 32'd1;
  assign wr_count   = mtc0_en & (A == 5'd9);
  assign wr_compare = mtc0_en & (A == 5'd11);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      presc   <= '0;
      ti      <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= Din;
        presc <= '0;
      end else if (tick) begin
        count <= count_inc;
        presc <= '0;
      end else begin
        presc <= presc + 32'd1;
      end
      // A Compare write clears TI even against a match in the same cycle.
      if (wr_compare) begin
        compare <= Din;
        ti      <= 1'b0;
      end else if (!wr_count && tick && (count_inc == compare)) begin
        ti <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;
  assign ti         = 1'b0;
  assign unused_cfg = (TIMER_DIV > 0);
`endif

  always_comb begin
    Dout = '0;
    case (A)
      5'd12: Dout = {16'b0, im, 8'b0, exl, ie};
      5'd13: Dout = {bd, ti, 14'b0, ip, 3'b0, exc_code, 2'b0};
      5'd14: Dout = {epc, 2'b00};
      5'd15: Dout = PRID_VAL;
      5'd8:  Dout = badvaddr;
`ifdef CP0_TIMER_UNIT_TIMER_EN
      5'd9:  Dout = count;
      5'd11: Dout = compare;
`endif
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_timer_unit.sv
// Directed bench for cp0_timer_unit: vector table for SR/Cause/EPC/exception arbitration,
// hand sequences for timer (when CP0_TIMER_UNIT_TIMER_EN is defined) and asynchronous reset.
`timescale 1ns/1ps
module tb_cp0_timer_unit;

  localparam logic [31:0] PRID = 32'h19260817;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] Din;
  logic        WE;
  logic [31:0] Dout;
  logic        ExcReq;
  logic [4:0]  ExcCodeIn;
  logic [29:0] PCIn;
  logic        BDIn;
  logic [31:0] BadVAddrIn;
  logic [5:0]  HWInt;
  logic        ExcNow;
  logic        EXLClr;
  logic [31:0] EPCOut;

  int n_cmp = 0;
  int n_err = 0;

  cp0_timer_unit #(.HWINT_W(6), .PRID_VAL(PRID), .TIMER_DIV(2)) dut (
    .clk(clk), .reset(reset), .A(A), .Din(Din), .WE(WE), .Dout(Dout),
    .ExcReq(ExcReq), .ExcCodeIn(ExcCodeIn), .PCIn(PCIn), .BDIn(BDIn),
    .BadVAddrIn(BadVAddrIn), .HWInt(HWInt), .ExcNow(ExcNow),
    .EXLClr(EXLClr), .EPCOut(EPCOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] din;
    logic        exc;
    logic [4:0]  code;
    logic [29:0] pc;
    logic        bd;
    logic [31:0] bva;
    logic [5:0]  hw;
    logic        clr;
    logic [4:0]  rd_a;
    logic [31:0] exp_dout;
    logic        exp_now;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    A = a;
    #0.5;
    chk(name, Dout, exp);
  endtask

  task automatic idle_ctl();
    WE = 1'b0; ExcReq = 1'b0; EXLClr = 1'b0;
    ExcCodeIn = '0; PCIn = '0; BDIn = 1'b0; BadVAddrIn = '0; Din = '0;
  endtask

  // One mtc0 cycle; returns just after the committing edge.
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    A = a; Din = d; WE = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic fill_vecs();
    //        we    a      din            exc   code   pc        bd    bva            hw     clr   rd_a   exp_dout       now
    vecs[0]  = '{1'b1, 5'd12, 32'h0000_0401, 1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd12, 32'h0000_0401, 1'b0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h01, 1'b0, 5'd13, 32'h0000_0400, 1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h100,  1'b0, 32'h0,         6'h01, 1'b0, 5'd12, 32'h0000_0403, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h01, 1'b0, 5'd14, 32'h0000_0400, 1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b1, 5'd12, 32'h0000_0401, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  30'hC01,  1'b1, 32'h3001,      6'h00, 1'b0, 5'd14, 32'h0000_3000, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd13, 32'h8000_0010, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd8,  32'h0000_3001, 1'b0};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h01, 1'b1, 5'd12, 32'h0000_0401, 1'b0};
    vecs[9]  = '{1'b1, 5'd12, 32'h0,         1'b1, 5'd10, 30'h300,  1'b0, 32'hDEAD,      6'h01, 1'b0, 5'd12, 32'h0000_0403, 1'b1};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd13, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd8,  32'h0000_3001, 1'b0};
    vecs[12] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd15, PRID,          1'b0};
    vecs[13] = '{1'b1, 5'd14, 32'h1234_5678, 1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd14, 32'h1234_5678, 1'b0};
    vecs[14] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd13, 32'h0000_0000, 1'b0};
    vecs[15] = '{1'b1, 5'd8,  32'hFFFF_FFFF, 1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd8,  32'h0000_3001, 1'b0};
    vecs[16] = '{1'b1, 5'd12, 32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b1, 5'd12, 32'h0000_0401, 1'b0};
    vecs[17] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd3,  32'h0000_0000, 1'b0};
    vecs[18] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  30'h40,   1'b0, 32'hABCD,      6'h00, 1'b0, 5'd8,  32'h0000_ABCD, 1'b1};
    vecs[19] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd12, 30'h80,   1'b0, 32'h1111,      6'h00, 1'b0, 5'd14, 32'h0000_0200, 1'b1};
    vecs[20] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b1, 5'd13, 32'h0000_0030, 1'b0};
    vecs[21] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  30'h0,    1'b0, 32'h0,         6'h00, 1'b0, 5'd8,  32'h0000_ABCD, 1'b0};
  endtask

  task automatic check_reset_state(input string tag);
    logic [4:0] addrs[7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    for (int i = 0; i < 7; i++)
      check_rd(addrs[i], (addrs[i] == 5'd15) ? PRID : 32'h0, $sformatf("%s_rd%0d", tag, addrs[i]));
    chk({tag, "_excnow"}, {31'b0, ExcNow}, 32'h0);
    chk({tag, "_epcout"}, EPCOut, 32'h0);
  endtask

  initial begin
    reset = 1'b0; A = '0; HWInt = '0;
    idle_ctl();
    fill_vecs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    reset = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      WE = vecs[i].we; A = vecs[i].a; Din = vecs[i].din;
      ExcReq = vecs[i].exc; ExcCodeIn = vecs[i].code; PCIn = vecs[i].pc;
      BDIn = vecs[i].bd; BadVAddrIn = vecs[i].bva; HWInt = vecs[i].hw; EXLClr = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d_now", i), {31'b0, ExcNow}, {31'b0, vecs[i].exp_now});
      @(posedge clk);
      #1;
      idle_ctl();
      check_rd(vecs[i].rd_a, vecs[i].exp_dout, $sformatf("vec%0d_rd%0d", i, vecs[i].rd_a));
    end
    chk("epcout", EPCOut, 32'h0000_0200);

`ifdef CP0_TIMER_UNIT_TIMER_EN
    // Count/Compare interrupt with TIMER_DIV=2: Count steps every second clock.
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9, 32'h100);
    mtc0(5'd11, 32'd3);
    mtc0(5'd9, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      check_rd(5'd9, 32'(k / 2), $sformatf("tmr_count_k%0d", k));
      chk($sformatf("tmr_now_k%0d", k), {31'b0, ExcNow}, {31'b0, (k >= 7)});
    end
    @(posedge clk);
    #1;
    check_rd(5'd13, 32'h4000_8000, "tmr_cause_taken");
    check_rd(5'd12, 32'h0000_8003, "tmr_sr_taken");
    mtc0(5'd11, 32'd100);
    check_rd(5'd13, 32'h0000_8000, "tmr_ti_clr");
    @(posedge clk);
    #1;
    check_rd(5'd13, 32'h0000_0000, "tmr_ip7_clr");

    // Wrap: 0xFFFFFFFF -> 0 matches Compare=0.
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    check_rd(5'd9, 32'hFFFF_FFFF, "wrap_cnt0");
    @(posedge clk);
    #1;
    check_rd(5'd9, 32'hFFFF_FFFF, "wrap_cnt1");
    @(posedge clk);
    #1;
    check_rd(5'd9, 32'h0, "wrap_cnt2");
    check_rd(5'd13, 32'h4000_0000, "wrap_ti");
    check_rd(5'd11, 32'h0, "wrap_cmp");

    // Compare write in the same cycle as a match leaves TI clear.
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    mtc0(5'd11, 32'd7);
    check_rd(5'd13, 32'h0, "cmpwr_at_match_ti");
    check_rd(5'd9, 32'h0, "cmpwr_at_match_cnt");
    check_rd(5'd11, 32'd7, "cmpwr_at_match_cmp");

    mtc0(5'd9, 32'd5);
    check_rd(5'd9, 32'd5, "pre_rst_count");
`else
    mtc0(5'd9, 32'h55);
    check_rd(5'd9, 32'h0, "notmr_rd9");
    mtc0(5'd11, 32'h77);
    check_rd(5'd11, 32'h0, "notmr_rd11");
    @(negedge clk);
    HWInt = 6'h20;
    @(posedge clk);
    #1;
    check_rd(5'd13, 32'h0000_8030, "notmr_ip7_hw5");
    @(negedge clk);
    HWInt = 6'h00;
    mtc0(5'd12, 32'h0000_0403);
`endif
    check_rd(5'd12, (`ifdef CP0_TIMER_UNIT_TIMER_EN 32'h0000_8003 `else 32'h0000_0403 `endif), "pre_rst_sr");

    // Asynchronous reset mid-run, away from any clock edge.
    @(negedge clk);
    #1;
    reset = 1'b0;
    #0.5;
    check_reset_state("async");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_timer_unit.md
Name: cp0_timer_unit

Overview:
- Parametrised system-control coprocessor for the pipelined MIPS core; successor of the fixed 6-interrupt CP0.
- Holds SR(12), Cause(13), EPC(14), PRId(15), BadVAddr(8), Count(9) and Compare(11).
- Arbitrates exceptions against masked hardware interrupts; the interrupt-line count is configurable.
- Adds an internal Count/Compare timer interrupt. Sits beside the M stage; the M stage drives mtc0/mfc0, exception requests and eret.

Parameters:
- HWINT_W, 6, number of external interrupt lines (1..6), mapped to IP[2+HWINT_W-1:2].
- PRID_VAL, 32'h19260817, constant returned for PRId.
- TIMER_DIV, 1, Count increments once every TIMER_DIV clocks (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- A  in  5  CP0 register number for mfc0/mtc0.
- Din  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- Dout  out  32  mfc0 read data, combinational.
- ExcReq  in  1  synchronous exception request from pipeline.
- ExcCodeIn  in  5  code of the requested exception.
- PCIn  in  30  word PC (bits 31:2) of the faulting/interrupted instruction.
- BDIn  in  1  instruction is in a delay slot.
- BadVAddrIn  in  32  faulting address for AdEL/AdES.
- HWInt  in  HWINT_W  external interrupt lines, level-sensitive.
- ExcNow  out  1  take exception this cycle, combinational.
- EXLClr  in  1  eret executing.
- EPCOut  out  32  {EPC,2'b0} for eret redirect.

Behaviour:
- Reset (reset=0, async): IM, EXL, IE, BD, IP, ExcCode, EPC, BadVAddr, Count, Compare, prescaler and TI are cleared to 0. Dout/ExcNow/EPCOut follow from the cleared registers (0 when inputs are idle).
- Read map:
  - 12: {16'b0,IM,8'b0,EXL,IE}
  - 13: {BD,TI,14'b0,IP,3'b0,ExcCode,2'b0}
  - 14: {EPC,2'b0}
  - 15: PRID_VAL
  - 8: BadVAddr
  - 9: Count
  - 11: Compare
  - any other A reads 0.
- IP register: each cycle IP[2+i] <= HWInt[i] for i<HWINT_W. IP[7] <= (HWINT_W==6 ? HWInt[5] : 0) | TI. Unused IP bits stay 0.
- IntReq = ~EXL & IE & |(IP & IM), computed from the registered IP (one-cycle sampling latency). ExcNow = ExcReq | IntReq.
- Update priority within a cycle: ExcNow > EXLClr > WE. A mtc0 in the same cycle as ExcNow or EXLClr is dropped.
- On ExcNow:
  - ExcCode <= IntReq ? 0 : ExcCodeIn. An interrupt beats a simultaneous exception.
  - BD <= BDIn; EPC <= BDIn ? PCIn-1 : PCIn.
  - EXL <= 1.
  - BadVAddr <= BadVAddrIn only when the exception is taken (not an interrupt) and ExcCodeIn is 4 or 5.
- On EXLClr (no ExcNow): EXL <= 0.
- mtc0 writes:
  - 12: IM, EXL and IE from Din[15:10], Din[1], Din[0].
  - 14: EPC <= Din[31:2].
  - 9: Count <= Din; prescaler <= 0.
  - 11: Compare <= Din; TI <= 0.
  - Writes to 8, 13, 15 and others are ignored.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1.
  - At the terminal value, Count <= Count+1 (wraps 32'hFFFFFFFF -> 0) and the prescaler returns to 0.
  - TI <= 1 when an increment produces Count == Compare. TI stays set until Compare is written or reset.
  - A Count write in the same cycle as an increment: the write wins and no match is evaluated.
  - A Compare write in the same cycle as a match: TI ends 0.
  - Count runs regardless of EXL/IE.
- Nested exceptions while EXL=1 are still taken if ExcReq=1 (EPC is overwritten); interrupts are blocked while EXL=1.

Optional Feature:
- Macro: CP0_TIMER_UNIT_TIMER_EN.
- Defined: Count, Compare, prescaler and TI exist as specified above.
- Undefined:
  - No timer logic.
  - Registers 9 and 11 read 0 and writes to them are ignored.
  - TI reads 0; IP[7] comes from HWInt[5] only.
  - TIMER_DIV has no effect.

Test Plan:
- Reset: drive reset=0 mid-run with EXL=1, Count=5 -> all reads return 0 immediately, PRId reads 32'h19260817.
- Interrupt: mtc0 SR=32'h0000_0401, HWInt[0]=1 -> ExcNow next cycle. Cause ExcCode=0, IP[2]=1, EXL=1. A second interrupt stays masked until eret.
- Delay slot: ExcReq=1, ExcCodeIn=4, PCIn=30'h0C01, BDIn=1, BadVAddrIn=32'h3001 -> EPC reads 32'h3000, BD=1, BadVAddr=32'h3001, ExcCode=4.
- Simultaneous: IntReq and ExcReq (code 10) in the same cycle as an SR write -> ExcCode=0 and the SR write is lost.
- Timer (TIMER_DIV=2): Compare=3, Count=0, IM[7]=1, IE=1 -> TI sets once Count reaches 3, about 6 cycles after the Count write, then ExcNow. Writing Compare clears TI.
- Wrap: Count=32'hFFFFFFFF, Compare=0 -> next increment gives Count=0 and TI=1. Repeat with the macro undefined -> reads of 9/11 return 0, no TI.
